fpu_issue_sched: RTL and testbench

- Compacting, age-ordered issue queue in front of the fixed-latency FPU pipeline (add/sub/mul/compare, SP and DP).
- Holds renamed FP ops until their source physical registers and FCR source are ready.
- Issues at most one op per cycle: the oldest ready op goes into the FPU `start` interface.
- Sits between rename/dispatch and the FPU. Also handles flush, and stalls issue when the shared writeback port is reserved.

---
 rtl/fpu_issue_sched_pkg.sv | 25 ++
 rtl/fpu_issue_sched_if.sv | 46 ++++
 rtl/fpu_issue_sched.sv | 140 ++++++++++++++
 tb/tb_fpu_issue_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_sched_pkg.sv
// Shared FP opcode encoding for the FPU issue path.
package fpu_issue_sched_pkg;

    typedef enum logic [3:0] {
        SP_ADD    = 4'd0,
        SP_SUB    = 4'd1,
        SP_MUL    = 4'd2,
        SP_CMP_LT = 4'd3,
        SP_CMP_LE = 4'd4,
        SP_CMP_EQ = 4'd5,
        DP_ADD    = 4'd6,
        DP_SUB    = 4'd7,
        DP_MUL    = 4'd8,
        DP_CMP_LT = 4'd9,
        DP_CMP_LE = 4'd10,
        DP_CMP_EQ = 4'd11
    } opcode_t;

    // Compares additionally depend on an FCR source.
    function automatic logic is_cmp(opcode_t op);
        return (op == SP_CMP_LT) || (op == SP_CMP_LE) || (op == SP_CMP_EQ) ||
               (op == DP_CMP_LT) || (op == DP_CMP_LE) || (op == DP_CMP_EQ);
    endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Dispatch-side enqueue handshake and FPU-side start bus of the FP issue queue.
interface fpu_issue_sched_if
    import fpu_issue_sched_pkg::*;
#(
    parameter int unsigned LG_PRF_WIDTH = 4,
    parameter int unsigned LG_ROB_WIDTH = 4,
    parameter int unsigned LG_FCR_WIDTH = 4
);
    logic                    enq_val;
    logic                    enq_rdy;
    opcode_t                 enq_opcode;
    logic [LG_PRF_WIDTH-1:0] enq_src_a;
    logic [LG_PRF_WIDTH-1:0] enq_src_b;
    logic [LG_FCR_WIDTH-1:0] enq_fcr_src;
    logic [LG_PRF_WIDTH-1:0] enq_dst;
    logic [LG_FCR_WIDTH-1:0] enq_fcr_dst;
    logic [2:0]              enq_fcr_sel;
    logic [LG_ROB_WIDTH-1:0] enq_rob;

    logic                    iss_val;
    opcode_t                 iss_opcode;
    logic [LG_PRF_WIDTH-1:0] iss_src_a;
    logic [LG_PRF_WIDTH-1:0] iss_src_b;
    logic [LG_FCR_WIDTH-1:0] iss_fcr_src;
    logic [LG_PRF_WIDTH-1:0] iss_dst;
    logic [LG_FCR_WIDTH-1:0] iss_fcr_dst;
    logic [2:0]              iss_fcr_sel;
    logic [LG_ROB_WIDTH-1:0] iss_rob;

    modport master (
        output enq_val, enq_opcode, enq_src_a, enq_src_b, enq_fcr_src,
               enq_dst, enq_fcr_dst, enq_fcr_sel, enq_rob,
        input  enq_rdy,
        input  iss_val, iss_opcode, iss_src_a, iss_src_b, iss_fcr_src,
               iss_dst, iss_fcr_dst, iss_fcr_sel, iss_rob
    );

    modport slave (
        input  enq_val, enq_opcode, enq_src_a, enq_src_b, enq_fcr_src,
               enq_dst, enq_fcr_dst, enq_fcr_sel, enq_rob,
        output enq_rdy,
        output iss_val, iss_opcode, iss_src_a, iss_src_b, iss_fcr_src,
               iss_dst, iss_fcr_dst, iss_fcr_sel, iss_rob
    );

endinterface

// File: rtl/fpu_issue_sched.sv
// Compacting age-ordered FP issue queue: holds renamed ops until operands are
// ready and starts the oldest ready one into the fixed-latency FPU each cycle.
module fpu_issue_sched
    import fpu_issue_sched_pkg::*;
#(
    parameter int unsigned N_ENTRIES    = 4,
    parameter int unsigned LG_PRF_WIDTH = 4,
    parameter int unsigned LG_ROB_WIDTH = 4,
    parameter int unsigned LG_FCR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [(2**LG_PRF_WIDTH)-1:0]   prf_rdy,
    input  logic [(2**LG_FCR_WIDTH)-1:0]   fcr_rdy,
    input  logic                           wb_block,
    output logic [$clog2(N_ENTRIES):0]     count,
    output logic                           empty,
    fpu_issue_sched_if.slave               ifc
);
    localparam int unsigned CNT_W = $clog2(N_ENTRIES) + 1;
    localparam int unsigned IDX_W = $clog2(N_ENTRIES);

    typedef struct packed {
        opcode_t                 opcode;
        logic [LG_PRF_WIDTH-1:0] src_a;
        logic [LG_PRF_WIDTH-1:0] src_b;
        logic [LG_FCR_WIDTH-1:0] fcr_src;
        logic [LG_PRF_WIDTH-1:0] dst;
        logic [LG_FCR_WIDTH-1:0] fcr_dst;
        logic [2:0]              fcr_sel;
        logic [LG_ROB_WIDTH-1:0] rob;
    } entry_t;

    entry_t               ent_q [N_ENTRIES];
    entry_t               ent_d [N_ENTRIES];
    logic [N_ENTRIES-1:0] vld_q;
    logic [N_ENTRIES-1:0] vld_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     wr_idx;
    logic [N_ENTRIES-1:0] rdy_c;
    logic [IDX_W-1:0]     sel;
    logic                 iss_fire;
    logic                 enq_fire;
    entry_t               enq_ent;

    // Per-entry readiness from the live register scoreboards.
    always_comb begin
        rdy_c = '0;
        for (int i = 0; i < int'(N_ENTRIES); i++) begin
            rdy_c[i] = vld_q[i]
                     & prf_rdy[ent_q[i].src_a]
                     & prf_rdy[ent_q[i].src_b]
                     & (~is_cmp(ent_q[i].opcode) | fcr_rdy[ent_q[i].fcr_src]);
        end
    end

    // Oldest ready entry wins: scan from the top so the lowest index sticks.
    always_comb begin
        sel = '0;
        for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
            if (rdy_c[i]) sel = IDX_W'(i);
        end
    end

    // Reset is treated like a flush so nothing escapes during it.
    assign iss_fire    = (|rdy_c) & ~wb_block & ~flush & ~reset;
    assign ifc.enq_rdy = (count_q < CNT_W'(N_ENTRIES));
    assign enq_fire    = ifc.enq_val & ifc.enq_rdy & ~flush;

    assign enq_ent = '{
        opcode:  ifc.enq_opcode,
        src_a:   ifc.enq_src_a,
        src_b:   ifc.enq_src_b,
        fcr_src: ifc.enq_fcr_src,
        dst:     ifc.enq_dst,
        fcr_dst: ifc.enq_fcr_dst,
        fcr_sel: ifc.enq_fcr_sel,
        rob:     ifc.enq_rob
    };

    assign ifc.iss_val     = iss_fire;
    assign ifc.iss_opcode  = ent_q[sel].opcode;
    assign ifc.iss_src_a   = ent_q[sel].src_a;
    assign ifc.iss_src_b   = ent_q[sel].src_b;
    assign ifc.iss_fcr_src = ent_q[sel].fcr_src;
    assign ifc.iss_dst     = ent_q[sel].dst;
    assign ifc.iss_fcr_dst = ent_q[sel].fcr_dst;
    assign ifc.iss_fcr_sel = ent_q[sel].fcr_sel;
    assign ifc.iss_rob     = ent_q[sel].rob;

    // Compaction above the issued slot, then the new op lands in the post-shift tail.
    always_comb begin
        ent_d   = ent_q;
        vld_d   = vld_q;
        wr_idx  = count_q - CNT_W'(iss_fire);
        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire);
        if (iss_fire) begin
            for (int i = 0; i < int'(N_ENTRIES) - 1; i++) begin
                if (i >= int'(sel)) begin
                    ent_d[i] = ent_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end
            end
            vld_d[N_ENTRIES-1] = 1'b0;
        end
        if (enq_fire) begin
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    ent_d[i] = enq_ent;
                    vld_d[i] = 1'b1;
                end
            end
        end
        if (flush) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; validity lives in vld_q.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: directed table/sequences plus random traffic
// checked against a queue-based model of the issue rules.
module tb_fpu_issue_sched;
    import fpu_issue_sched_pkg::*;

    localparam int N = 4;

    typedef struct {
        opcode_t    op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] fs;
        logic [3:0] d;
        logic [3:0] fd;
        logic [2:0] sel;
        logic [3:0] rob;
    } op_t;

    typedef struct {
        logic       enq;
        logic [3:0] dst;
        logic       exp_iss;
        logic [3:0] exp_dst;
        int         exp_cnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] prf_rdy;
    logic [15:0] fcr_rdy;
    logic        wb_block;
    logic [2:0]  count;
    logic        empty;

    fpu_issue_sched_if #(.LG_PRF_WIDTH(4), .LG_ROB_WIDTH(4), .LG_FCR_WIDTH(4)) ifc ();

    fpu_issue_sched #(
        .N_ENTRIES(N), .LG_PRF_WIDTH(4), .LG_ROB_WIDTH(4), .LG_FCR_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .prf_rdy(prf_rdy),
        .fcr_rdy(fcr_rdy), .wb_block(wb_block), .count(count), .empty(empty),
        .ifc(ifc)
    );

    always #5 clk = ~clk;

    int   checks;
    int   errors;
    bit   chk_en;
    op_t  q[$];
    vec_t tbl[6];

    logic       s_iss;
    logic       s_rdy;
    logic       s_empty;
    logic [3:0] s_dst;
    logic [3:0] s_fdst;
    logic [2:0] s_fsel;
    int         s_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_ready(op_t o);
        bit cmp;
        cmp = o.op inside {SP_CMP_LT, SP_CMP_LE, SP_CMP_EQ, DP_CMP_LT, DP_CMP_LE, DP_CMP_EQ};
        return prf_rdy[o.a] && prf_rdy[o.b] && (!cmp || fcr_rdy[o.fs]);
    endfunction

    task automatic set_op(input opcode_t op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] fs, input logic [3:0] d, input logic [3:0] fd,
                          input logic [2:0] sel, input logic [3:0] rob);
        ifc.enq_val     = 1'b1;
        ifc.enq_opcode  = op;
        ifc.enq_src_a   = a;
        ifc.enq_src_b   = b;
        ifc.enq_fcr_src = fs;
        ifc.enq_dst     = d;
        ifc.enq_fcr_dst = fd;
        ifc.enq_fcr_sel = sel;
        ifc.enq_rob     = rob;
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic cycle();
        int  k;
        bit  acc;
        op_t o;
        @(negedge clk);
        k = -1;
        if (!reset && !flush && !wb_block) begin
            for (int i = 0; i < q.size(); i++) begin
                if (op_ready(q[i])) begin
                    k = i;
                    break;
                end
            end
        end
        s_iss   = ifc.iss_val;
        s_dst   = ifc.iss_dst;
        s_fdst  = ifc.iss_fcr_dst;
        s_fsel  = ifc.iss_fcr_sel;
        s_rdy   = ifc.enq_rdy;
        s_empty = empty;
        s_cnt   = int'(count);
        if (chk_en) begin
            chk("iss_val", 64'(ifc.iss_val), 64'(k >= 0));
            if (k >= 0) begin
                chk("iss_opcode",  64'(ifc.iss_opcode),  64'(q[k].op));
                chk("iss_src_a",   64'(ifc.iss_src_a),   64'(q[k].a));
                chk("iss_src_b",   64'(ifc.iss_src_b),   64'(q[k].b));
                chk("iss_fcr_src", 64'(ifc.iss_fcr_src), 64'(q[k].fs));
                chk("iss_dst",     64'(ifc.iss_dst),     64'(q[k].d));
                chk("iss_fcr_dst", 64'(ifc.iss_fcr_dst), 64'(q[k].fd));
                chk("iss_fcr_sel", 64'(ifc.iss_fcr_sel), 64'(q[k].sel));
                chk("iss_rob",     64'(ifc.iss_rob),     64'(q[k].rob));
            end
            chk("count",       64'(count),       64'(q.size()));
            chk("empty",       64'(empty),       64'(q.size() == 0));
            chk("enq_rdy",     64'(ifc.enq_rdy), 64'(q.size() < N));
            chk("count_bound", 64'(count <= 3'(N)), 64'd1);
            chk("iss_while_wb_block", 64'(ifc.iss_val & wb_block), 64'd0);
            chk("valid_contig", 64'(dut.vld_q), 64'((1 << q.size()) - 1));
        end
        acc = ifc.enq_val && (q.size() < N) && !flush && !reset;
        o = '{ifc.enq_opcode, ifc.enq_src_a, ifc.enq_src_b, ifc.enq_fcr_src,
              ifc.enq_dst, ifc.enq_fcr_dst, ifc.enq_fcr_sel, ifc.enq_rob};
        @(posedge clk);
        #1;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (k >= 0) q.delete(k);
            if (acc) q.push_back(o);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.enq_val = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        clk = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        wb_block = 1'b0;
        prf_rdy = '1;
        fcr_rdy = '1;
        set_op(SP_ADD, 0, 0, 0, 0, 0, 0, 0);
        ifc.enq_val = 1'b0;
        cycle();
        cycle();
        chk_en = 1'b1;
        reset = 1'b0;

        // Back-to-back ready DP_ADDs stream through with one-cycle latency.
        tbl[0] = '{1'b1, 4'd1, 1'b0, 4'd0, 0};
        tbl[1] = '{1'b1, 4'd2, 1'b1, 4'd1, 1};
        tbl[2] = '{1'b1, 4'd3, 1'b1, 4'd2, 1};
        tbl[3] = '{1'b1, 4'd4, 1'b1, 4'd3, 1};
        tbl[4] = '{1'b0, 4'd0, 1'b1, 4'd4, 1};
        tbl[5] = '{1'b0, 4'd0, 1'b0, 4'd0, 0};
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_enq_rdy", 64'(ifc.enq_rdy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            set_op(DP_ADD, 4'd0, 4'd0, 4'd0, tbl[i].dst, 4'd0, 3'd0, 4'(i));
            ifc.enq_val = tbl[i].enq;
            cycle();
            chk("tbl_iss_val", 64'(s_iss), 64'(tbl[i].exp_iss));
            if (tbl[i].exp_iss) chk("tbl_iss_dst", 64'(s_dst), 64'(tbl[i].exp_dst));
            chk("tbl_count", 64'(s_cnt), 64'(tbl[i].exp_cnt));
        end

        // Fill with nothing ready; overflow enqueue is dropped; middle entry issues.
        do_reset();
        prf_rdy = '0;
        for (int i = 0; i < 4; i++) begin
            set_op(DP_MUL, 4'(2*i), 4'(2*i+1), 4'd0, 4'(10+i), 4'd0, 3'd0, 4'(i));
            cycle();
        end
        set_op(DP_MUL, 4'd8, 4'd9, 4'd0, 4'd14, 4'd0, 3'd0, 4'd4);
        cycle();
        chk("full_enq_rdy", 64'(s_rdy), 64'd0);
        chk("full_count", 64'(s_cnt), 64'd4);
        ifc.enq_val = 1'b0;
        prf_rdy = 16'h0030;
        cycle();
        chk("mid_iss_val", 64'(s_iss), 64'd1);
        chk("mid_iss_dst", 64'(s_dst), 64'd12);
        cycle();
        chk("mid_count_after", 64'(s_cnt), 64'd3);

        // Full queue with oldest ready: no accept on the issue cycle, accept next.
        set_op(DP_MUL, 4'd8, 4'd9, 4'd0, 4'd14, 4'd0, 3'd0, 4'd5);
        cycle();
        prf_rdy = 16'h0033;
        set_op(DP_MUL, 4'd8, 4'd9, 4'd0, 4'd15, 4'd0, 3'd0, 4'd6);
        cycle();
        chk("fi_iss_dst", 64'(s_dst), 64'd10);
        chk("fi_enq_rdy", 64'(s_rdy), 64'd0);
        cycle();
        chk("fi_enq_rdy_next", 64'(s_rdy), 64'd1);
        chk("fi_count_next", 64'(s_cnt), 64'd3);
        ifc.enq_val = 1'b0;
        cycle();
        chk("fi_count_refill", 64'(s_cnt), 64'd4);

        // Compare waits on FCR readiness while a younger multiply overtakes it.
        do_reset();
        prf_rdy = '1;
        fcr_rdy = '0;
        set_op(SP_CMP_LT, 4'd1, 4'd2, 4'd3, 4'd1, 4'd5, 3'd6, 4'd7);
        cycle();
        set_op(SP_MUL, 4'd3, 4'd4, 4'd0, 4'd2, 4'd0, 3'd0, 4'd8);
        cycle();
        ifc.enq_val = 1'b0;
        cycle();
        chk("cmp_mul_first", 64'(s_dst), 64'd2);
        cycle();
        chk("cmp_blocked", 64'(s_iss), 64'd0);
        fcr_rdy = 16'h0008;
        cycle();
        chk("cmp_iss_val", 64'(s_iss), 64'd1);
        chk("cmp_iss_dst", 64'(s_dst), 64'd1);
        chk("cmp_fcr_sel", 64'(s_fsel), 64'd6);
        chk("cmp_fcr_dst", 64'(s_fdst), 64'd5);

        // Writeback reservation stalls issue until it drops.
        do_reset();
        fcr_rdy = '1;
        wb_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(DP_MUL, 4'd0, 4'd1, 4'd0, 4'(i+1), 4'd0, 3'd0, 4'(i));
            cycle();
        end
        ifc.enq_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wb_block_stall", 64'(s_iss), 64'd0);
        end
        wb_block = 1'b0;
        cycle();
        chk("wb_resume_val", 64'(s_iss), 64'd1);
        chk("wb_resume_dst", 64'(s_dst), 64'd1);

        // Flush with a same-cycle enqueue, then reset mid-operation.
        do_reset();
        prf_rdy = '0;
        for (int i = 0; i < 3; i++) begin
            set_op(SP_ADD, 4'd0, 4'd1, 4'd0, 4'(4+i), 4'd0, 3'd0, 4'(i));
            cycle();
        end
        flush = 1'b1;
        set_op(SP_ADD, 4'd2, 4'd3, 4'd0, 4'd9, 4'd0, 3'd0, 4'd9);
        cycle();
        chk("flush_iss", 64'(s_iss), 64'd0);
        flush = 1'b0;
        ifc.enq_val = 1'b0;
        cycle();
        chk("flush_count", 64'(s_cnt), 64'd0);
        chk("flush_empty", 64'(s_empty), 64'd1);
        prf_rdy = '1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_no_ghost", 64'(s_iss), 64'd0);
        end
        prf_rdy = '0;
        for (int i = 0; i < 3; i++) begin
            set_op(SP_SUB, 4'd0, 4'd1, 4'd0, 4'(4+i), 4'd0, 3'd0, 4'(i));
            cycle();
        end
        reset = 1'b1;
        set_op(SP_SUB, 4'd2, 4'd3, 4'd0, 4'd9, 4'd0, 3'd0, 4'd9);
        cycle();
        chk("rst_mid_iss", 64'(s_iss), 64'd0);
        reset = 1'b0;
        ifc.enq_val = 1'b0;
        cycle();
        chk("rst_mid_count", 64'(s_cnt), 64'd0);
        chk("rst_mid_empty", 64'(s_empty), 64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            set_op(opcode_t'($urandom_range(0, 11)), 4'($urandom), 4'($urandom),
                   4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom));
            ifc.enq_val = ($urandom_range(0, 9) < 7);
            prf_rdy  = 16'($urandom) | 16'($urandom);
            fcr_rdy  = 16'($urandom) | 16'($urandom);
            wb_block = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 3);
            reset    = ($urandom_range(0, 99) < 1);
            cycle();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
